burst_prbs_checker: RTL and testbench

//  Receive-side partner of the XG-PON burst PRBS generator. Sits on the 32-bit AXIS RX output of the
//  10G Ethernet GTH path (axis_rx_clk domain). Hunts for the burst preamble syncword, self-seeds a

---
 rtl/burst_pon_pkg.sv | 35 +++
 rtl/prbs31_par32.sv | 18 +
 rtl/burst_prbs_checker.sv | 208 ++++++++++++++++++++
 tb/tb_burst_prbs_checker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pon_pkg.sv
// Shared types and PRBS-31 stepping function for the XG-PON burst generator/checker pair.
// PRBS-31 is x^31+x^28+1, Fibonacci form, emitted MSB-first (oldest bit in word[31]).
package burst_pon_pkg;

    typedef enum logic [1:0] {
        HUNT,
        ARMED,
        CHECK
    } chk_state_t;

    localparam int unsigned PRBS31_TAP_A = 31;
    localparam int unsigned PRBS31_TAP_B = 28;

    typedef struct packed {
        logic [31:0] word;
        logic [30:0] lfsr;
    } prbs31_step_t;

    // lfsr[0] holds the newest bit, so seeding from tdata[30:0] of a line word continues the sequence.
    function automatic prbs31_step_t prbs31_next32(input logic [30:0] lfsr);
        prbs31_step_t r;
        logic [30:0]  s;
        logic         b;
        s      = lfsr;
        r.word = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b      = s[PRBS31_TAP_A-1] ^ s[PRBS31_TAP_B-1];
            r.word = {r.word[30:0], b};
            s      = {s[29:0], b};
        end
        r.lfsr = s;
        return r;
    endfunction

endpackage

// File: rtl/prbs31_par32.sv
// Combinational 32-bit-per-clock PRBS-31 step: expected word and advanced state.
module prbs31_par32
    import burst_pon_pkg::*;
(
    input  logic [30:0] i_lfsr,
    output logic [31:0] o_word,
    output logic [30:0] o_lfsr
);

    prbs31_step_t w_step;

    always_comb begin
        w_step = prbs31_next32(i_lfsr);
        o_word = w_step.word;
        o_lfsr = w_step.lfsr;
    end

endmodule

// File: rtl/burst_prbs_checker.sv
// Burst PRBS-31 checker: syncword hunt, self-seeded predictor, saturating error/burst statistics.
// Optional first-error capture ports are enabled by defining BURST_CHK_FIRST_ERR_EN.
module burst_prbs_checker
    import burst_pon_pkg::*;
#(
    parameter logic [31:0] SYNCWORD    = 32'h05560556,
    parameter int unsigned SYNC_THRESH = 5,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             axis_rx_clk,
    input  logic             axis_resetn,
    input  logic             stat_clr,
    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic             locked,
    output logic [CNT_W-1:0] err_bits,
    output logic [CNT_W-1:0] err_words,
    output logic [CNT_W-1:0] bursts_ok,
    output logic [CNT_W-1:0] bursts_bad,
    output logic [CNT_W-1:0] bursts_missed
`ifdef BURST_CHK_FIRST_ERR_EN
    ,
    output logic             first_err_valid,
    output logic [31:0]      first_err_exp,
    output logic [31:0]      first_err_rx,
    output logic [15:0]      first_err_beat
`endif
);

    localparam logic [7:0] SYNC_THRESH_M1 = 8'(SYNC_THRESH - 1);

    chk_state_t  r_state, w_state_nxt;
    logic [7:0]  r_sync_cnt, w_sync_cnt_nxt;
    logic [30:0] r_lfsr, w_lfsr_nxt, w_lfsr_step;
    logic [31:0] w_exp, w_mask, w_xor;
    logic        w_is_sync, w_chk_beat, w_inc_ok, w_inc_bad, w_inc_missed;
    logic [31:0] r_xor, w_pop_shift;
    logic        r_xor_vld;
    logic [5:0]  w_pop;
    logic [CNT_W-1:0] r_err_bits, r_err_words, r_bursts_ok, r_bursts_bad, r_bursts_missed;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [5:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-5){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    prbs31_par32 u_prbs (
        .i_lfsr (r_lfsr),
        .o_word (w_exp),
        .o_lfsr (w_lfsr_step)
    );

    assign s_axis_tready = 1'b1;
    assign locked        = (r_state == CHECK);
    assign err_bits      = r_err_bits;
    assign err_words     = r_err_words;
    assign bursts_ok     = r_bursts_ok;
    assign bursts_bad    = r_bursts_bad;
    assign bursts_missed = r_bursts_missed;

    always_comb begin
        w_is_sync = (s_axis_tdata == SYNCWORD);
        w_mask    = {{8{s_axis_tkeep[3]}}, {8{s_axis_tkeep[2]}},
                     {8{s_axis_tkeep[1]}}, {8{s_axis_tkeep[0]}}};
        w_xor     = (w_exp ^ s_axis_tdata) & w_mask;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        w_lfsr_nxt     = r_lfsr;
        w_chk_beat     = 1'b0;
        w_inc_ok       = 1'b0;
        w_inc_bad      = 1'b0;
        w_inc_missed   = 1'b0;
        if (s_axis_tvalid) begin
            unique case (r_state)
                HUNT: begin
                    if (!w_is_sync) begin
                        w_sync_cnt_nxt = '0;
                    end else if (r_sync_cnt == SYNC_THRESH_M1) begin
                        w_state_nxt    = ARMED;
                        w_sync_cnt_nxt = '0;
                    end else begin
                        w_sync_cnt_nxt = r_sync_cnt + 8'd1;
                    end
                end
                ARMED: begin
                    if (!w_is_sync) begin
                        w_lfsr_nxt  = s_axis_tdata[30:0];
                        w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    w_chk_beat = 1'b1;
                    w_lfsr_nxt = w_lfsr_step;
                end
                default: w_state_nxt = HUNT;
            endcase
            // tlast overrides any transition chosen above, including arming on the same beat.
            if (s_axis_tlast) begin
                w_state_nxt    = HUNT;
                w_sync_cnt_nxt = '0;
                if (r_state == CHECK) begin
                    w_inc_ok  = !s_axis_tuser;
                    w_inc_bad = s_axis_tuser;
                end else begin
                    w_inc_missed = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axis_rx_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge axis_rx_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_sync_cnt <= '0;
            r_lfsr     <= '0;
            r_xor      <= '0;
            r_xor_vld  <= 1'b0;
        end else begin
            r_sync_cnt <= w_sync_cnt_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_xor      <= w_xor;
            r_xor_vld  <= w_chk_beat && !stat_clr;
        end
    end

    always_comb begin
        w_pop       = '0;
        w_pop_shift = r_xor;
        for (int unsigned i = 0; i < 32; i++) begin
            w_pop       = w_pop + {5'd0, w_pop_shift[0]};
            w_pop_shift = w_pop_shift >> 1;
        end
    end

    always_ff @(posedge axis_rx_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_err_bits      <= '0;
            r_err_words     <= '0;
            r_bursts_ok     <= '0;
            r_bursts_bad    <= '0;
            r_bursts_missed <= '0;
        end else if (stat_clr) begin
            r_err_bits      <= '0;
            r_err_words     <= '0;
            r_bursts_ok     <= '0;
            r_bursts_bad    <= '0;
            r_bursts_missed <= '0;
        end else begin
            if (r_xor_vld && (r_xor != '0)) begin
                r_err_bits  <= sat_add(r_err_bits, w_pop);
                r_err_words <= sat_add(r_err_words, 6'd1);
            end
            if (w_inc_ok)     r_bursts_ok     <= sat_add(r_bursts_ok, 6'd1);
            if (w_inc_bad)    r_bursts_bad    <= sat_add(r_bursts_bad, 6'd1);
            if (w_inc_missed) r_bursts_missed <= sat_add(r_bursts_missed, 6'd1);
        end
    end

`ifdef BURST_CHK_FIRST_ERR_EN
    logic        w_seed_beat;
    logic [15:0] r_beat_idx;

    assign w_seed_beat = s_axis_tvalid && (r_state == ARMED) && !w_is_sync;

    always_ff @(posedge axis_rx_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_beat_idx      <= '0;
            first_err_valid <= 1'b0;
            first_err_exp   <= '0;
            first_err_rx    <= '0;
            first_err_beat  <= '0;
        end else begin
            if (w_seed_beat) begin
                r_beat_idx <= 16'd1;
            end else if (w_chk_beat) begin
                r_beat_idx <= r_beat_idx + 16'd1;
            end
            if (stat_clr) begin
                first_err_valid <= 1'b0;
                first_err_exp   <= '0;
                first_err_rx    <= '0;
                first_err_beat  <= '0;
            end else if (w_chk_beat && (w_xor != '0) && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_exp   <= w_exp;
                first_err_rx    <= s_axis_tdata;
                first_err_beat  <= r_beat_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_burst_prbs_checker.sv
// Directed self-checking bench for burst_prbs_checker; expected PRBS words come from a bit-serial model.
module tb_burst_prbs_checker;

    localparam logic [31:0] SYNC  = 32'h05560556;
    localparam int          NWORD = 101;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stat_clr;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast, tuser;
    logic        tready, locked;
    logic [31:0] err_bits, err_words, bursts_ok, bursts_bad, bursts_missed;
`ifdef BURST_CHK_FIRST_ERR_EN
    logic        fe_valid;
    logic [31:0] fe_exp, fe_rx;
    logic [15:0] fe_beat;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned lock_cnt = 0;
    int unsigned lock_base;

    bit          pbits [0:32*NWORD-1];
    logic [31:0] pwords [0:NWORD-1];
    logic [31:0] err_pat [0:NWORD-1];

    always #5 clk = ~clk;

    always @(negedge clk) if (locked) lock_cnt++;

    burst_prbs_checker #(
        .SYNCWORD    (SYNC),
        .SYNC_THRESH (5),
        .CNT_W       (32)
    ) dut (
        .axis_rx_clk   (clk),
        .axis_resetn   (rstn),
        .stat_clr      (stat_clr),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tuser  (tuser),
        .s_axis_tready (tready),
        .locked        (locked),
        .err_bits      (err_bits),
        .err_words     (err_words),
        .bursts_ok     (bursts_ok),
        .bursts_bad    (bursts_bad),
        .bursts_missed (bursts_missed)
`ifdef BURST_CHK_FIRST_ERR_EN
        ,
        .first_err_valid (fe_valid),
        .first_err_exp   (fe_exp),
        .first_err_rx    (fe_rx),
        .first_err_beat  (fe_beat)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference: b[n] = b[n-31] ^ b[n-28], bit 0 is the oldest (tdata[31]) of word 0.
    task automatic build_prbs(input logic [31:0] seed);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) pbits[i] = seed[31-i];
        for (int n = 32; n < 32*NWORD; n++) pbits[n] = pbits[n-31] ^ pbits[n-28];
        for (int k = 0; k < NWORD; k++) begin
            w = '0;
            for (int j = 0; j < 32; j++) w = {w[30:0], pbits[32*k+j]};
            pwords[k] = w;
        end
    endtask

    task automatic clear_errs();
        for (int k = 0; k < NWORD; k++) err_pat[k] = '0;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tuser  = u;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid   = 1'b0;
        tlast    = 1'b0;
        tuser    = 1'b0;
        stat_clr = 1'b0;
    endtask

    task automatic send_syncs(input int n);
        for (int i = 0; i < n; i++) send(SYNC, 4'hF, 1'b0, 1'b0);
    endtask

    task automatic send_words(input int from, input int to, input logic last, input logic user);
        for (int k = from; k <= to; k++)
            send(pwords[k] ^ err_pat[k], 4'hF, last && (k == to), user);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; stat_clr = 1'b0; tdata = '0; tkeep = 4'hF;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        build_prbs(32'h1234_5678);
        clear_errs();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        idle(1);

        check_eq("rst_tready", {31'd0, tready}, 32'd1);
        check_eq("rst_locked", {31'd0, locked}, 32'd0);
        check_eq("rst_err_bits", err_bits, 32'd0);
        check_eq("rst_err_words", err_words, 32'd0);
        check_eq("rst_ok", bursts_ok, 32'd0);
        check_eq("rst_bad", bursts_bad, 32'd0);
        check_eq("rst_missed", bursts_missed, 32'd0);

        // Clean burst
        send_syncs(5);
        check_eq("clean_lock_after5", {31'd0, locked}, 32'd0);
        send_words(0, 0, 1'b0, 1'b0);
        check_eq("clean_lock_after6", {31'd0, locked}, 32'd1);
        send_words(1, 100, 1'b1, 1'b0);
        check_eq("clean_unlock", {31'd0, locked}, 32'd0);
        check_eq("clean_ok_1cyc", bursts_ok, 32'd1);
        idle(3);
        check_eq("clean_err_bits", err_bits, 32'd0);
        check_eq("clean_err_words", err_words, 32'd0);
        check_eq("clean_missed", bursts_missed, 32'd0);

        pulse_clr();
        check_eq("clr_ok", bursts_ok, 32'd0);

        // Injected errors: 1 + 1 + 8 bits on beats 10, 20, 30
        err_pat[10] = 32'h0000_0001;
        err_pat[20] = 32'h0000_0001;
        err_pat[30] = 32'hFF00_0000;
        send_syncs(5);
        send_words(0, 10, 1'b0, 1'b0);
        check_eq("err_lat_1cyc", err_words, 32'd0);
        send_words(11, 11, 1'b0, 1'b0);
        check_eq("err_lat_2cyc_words", err_words, 32'd1);
        check_eq("err_lat_2cyc_bits", err_bits, 32'd1);
        send_words(12, 100, 1'b1, 1'b0);
        idle(3);
        check_eq("err_words", err_words, 32'd3);
        check_eq("err_bits", err_bits, 32'd10);
        check_eq("err_ok", bursts_ok, 32'd1);
`ifdef BURST_CHK_FIRST_ERR_EN
        check_eq("fe_valid", {31'd0, fe_valid}, 32'd1);
        check_eq("fe_beat", {16'd0, fe_beat}, 32'd10);
        check_eq("fe_exp", fe_exp, pwords[10]);
        check_eq("fe_rx", fe_rx, pwords[10] ^ 32'h1);
`endif

        // Too few syncwords: burst is missed, never locks
        clear_errs();
        pulse_clr();
        lock_base = lock_cnt;
        send_syncs(4);
        send_words(0, 20, 1'b1, 1'b0);
        idle(3);
        check_eq("miss_missed", bursts_missed, 32'd1);
        check_eq("miss_ok", bursts_ok, 32'd0);
        check_eq("miss_never_locked", lock_cnt - lock_base, 32'd0);

        // Partial last beat with garbage in masked bytes, bad-frame flag
        pulse_clr();
        send_syncs(5);
        send_words(0, 19, 1'b0, 1'b0);
        send(pwords[20] ^ 32'hABCD_0000, 4'b0011, 1'b1, 1'b1);
        idle(3);
        check_eq("keep_err_bits", err_bits, 32'd0);
        check_eq("keep_err_words", err_words, 32'd0);
        check_eq("bad_bad", bursts_bad, 32'd1);
        check_eq("bad_ok", bursts_ok, 32'd0);

        // stat_clr coincident with the final errored beat, another result still in flight
        err_pat[5]  = 32'h0000_0001;
        err_pat[14] = 32'h0000_0002;
        err_pat[15] = 32'h0000_0004;
        send_syncs(5);
        send_words(0, 14, 1'b0, 1'b0);
        check_eq("clr_pre_words", err_words, 32'd1);
        stat_clr = 1'b1;
        send_words(15, 15, 1'b1, 1'b0);
        idle(3);
        check_eq("clr_err_bits", err_bits, 32'd0);
        check_eq("clr_err_words", err_words, 32'd0);
        check_eq("clr_ok2", bursts_ok, 32'd0);
        check_eq("clr_bad", bursts_bad, 32'd0);
        check_eq("clr_missed", bursts_missed, 32'd0);
`ifdef BURST_CHK_FIRST_ERR_EN
        check_eq("clr_fe_valid", {31'd0, fe_valid}, 32'd0);
`endif

        // Reset mid-CHECK with an error accumulated and another in flight
        clear_errs();
        err_pat[3] = 32'h0000_0001;
        err_pat[8] = 32'h0000_0010;
        send_syncs(5);
        send_words(0, 8, 1'b0, 1'b0);
        check_eq("rstmid_locked_pre", {31'd0, locked}, 32'd1);
        check_eq("rstmid_words_pre", err_words, 32'd1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstmid_locked", {31'd0, locked}, 32'd0);
        check_eq("rstmid_words", err_words, 32'd0);
        rstn = 1'b1;
        idle(1);
        check_eq("rstmid_words_flushed", err_words, 32'd0);
        clear_errs();
        send_syncs(5);
        send_words(0, 30, 1'b1, 1'b0);
        idle(3);
        check_eq("post_rst_ok", bursts_ok, 32'd1);
        check_eq("post_rst_err_bits", err_bits, 32'd0);
        check_eq("post_rst_missed", bursts_missed, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
